// File: rtl/seq_slice_sub_pkg.sv
// Shared types and elaboration helpers for the sequential slice subtractor.
package seq_slice_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices needed to cover an operand.
    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice index width; kept at least one bit wide so a single-slice build still has a counter.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_slice_subtractor_sub_slice.sv
// Combinational SLICE-bit subtract cell: {borrow_out, d} = a_s - b_s - borrow_in.
module sub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             borrow_in,
    output logic [SLICE-1:0] d,
    output logic             borrow_out
);

    // One extra bit on top catches the borrow: a negative result wraps into bit SLICE.
    logic [SLICE:0] res;

    assign res        = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, borrow_in};
    assign d          = res[SLICE-1:0];
    assign borrow_out = res[SLICE];

endmodule

// File: rtl/seq_slice_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB first.
module seq_slice_subtractor
    import seq_slice_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int             NSLICE     = nslice(WIDTH, SLICE);
    localparam int             IW         = idx_w(NSLICE);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    if (WIDTH % SLICE != 0) begin : g_width_check
        $error("seq_slice_subtractor: WIDTH must be an integer multiple of SLICE");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  diff_q, diff_next;
    logic [IW-1:0]     idx_q;
    logic              borrow_q;
    logic              bout_q, zero_q;

    logic [31:0]       bit_off;
    logic [SLICE-1:0]  a_s, b_s, d_s;
    logic              borrow_n;
    logic              last_slice;

    // Select the active slice of the captured operands and splice its result into diff.
    assign bit_off    = 32'(idx_q) * 32'(SLICE);
    assign a_s        = SLICE'(a_q >> bit_off);
    assign b_s        = SLICE'(b_q >> bit_off);
    assign last_slice = (idx_q == LAST_IDX);
    assign diff_next  = (diff_q & ~(SLICE_MASK << bit_off)) | (WIDTH'(d_s) << bit_off);

    sub_slice #(.SLICE(SLICE)) u_cell (
        .a_s       (a_s),
        .b_s       (b_s),
        .borrow_in (borrow_q),
        .d         (d_s),
        .borrow_out(borrow_n)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode: accept only in IDLE, walk all slices, hold result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Operand capture; contents only matter while RUN, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Slice walk: clear diff on accept, ripple borrow through the register, finalise flags on the last slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        diff_q   <= '0;
                        borrow_q <= bin;
                        idx_q    <= '0;
                    end
                end
                RUN: begin
                    diff_q   <= diff_next;
                    borrow_q <= borrow_n;
                    idx_q    <= idx_q + 1'b1;
                    if (last_slice) begin
                        bout_q <= borrow_n;
                        zero_q <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_slice_subtractor.sv
// Scoreboard bench for seq_slice_subtractor at default WIDTH=32, SLICE=8.
module tb_seq_slice_subtractor;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_slice_subtractor #(.WIDTH(32), .SLICE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Reference: full-width subtract with one extra bit for the borrow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] r;
        exp_t e;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.diff = r[W-1:0];
        e.bout = r[W];
        e.zero = (r[W-1:0] == '0);
        return e;
    endfunction

    // Present operands for one cycle (DUT assumed idle) and record the expected result.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit push);
        a = x; b = y; bin = bi; in_valid = 1'b1;
        if (push) sb.push_back(model(x, y, bi));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; cycles counts edges after the accept edge.
    task automatic wait_out(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (diff !== '0)        begin n_err++; $display("FAIL reset_diff: got %h want 0", diff); end
        n_cmp++; if (bout !== 1'b0)      begin n_err++; $display("FAIL reset_bout: got %b want 0", bout); end
        n_cmp++; if (zero !== 1'b0)      begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[5] = '{32'h0000_0005, 32'h0000_0100, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [W-1:0] vb[5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h1234_5677, 32'hDEAD_BEEF};
        logic         vi[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            send(va[i], vb[i], vi[i], 1'b1);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL vec%0d_busy_in_ready: got %b want 0", i, in_ready); end
            n_cmp++; if (diff !== '0) begin n_err++; $display("FAIL vec%0d_cleared_diff: got %h want 0", i, diff); end
            wait_out(cyc);
            n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL vec%0d_latency: got %0d cycles want 4", i, cyc); end
            if (sb.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL vec%0d_scoreboard: got empty want entry", i);
            end else begin
                e = sb.pop_front();
                n_cmp++; if (diff !== e.diff) begin n_err++; $display("FAIL vec%0d_diff: got %h want %h", i, diff, e.diff); end
                n_cmp++; if (bout !== e.bout) begin n_err++; $display("FAIL vec%0d_bout: got %b want %b", i, bout, e.bout); end
                n_cmp++; if (zero !== e.zero) begin n_err++; $display("FAIL vec%0d_zero: got %b want %b", i, zero, e.zero); end
            end
            take_out();
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_release: got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        exp_t e;
        send(32'hA5A5_0000, 32'h1234_5678, 1'b0, 1'b1);
        wait_out(cyc);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid); end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        for (int k = 0; k < 5; k++) begin
            a = $urandom; b = $urandom; bin = k[0]; in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++; if (diff !== e.diff || bout !== e.bout || zero !== e.zero)
                begin n_err++; $display("FAIL bp_hold%0d: got %h/%b/%b want %h/%b/%b", k, diff, bout, zero, e.diff, e.bout, e.zero); end
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
                begin n_err++; $display("FAIL bp_ctrl%0d: got ir=%b ov=%b want ir=0 ov=1", k, in_ready, out_valid); end
        end
        in_valid = 1'b0;
        take_out();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_queue: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        wait_out(cyc);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if (cyc !== 4 || diff !== e.diff || bout !== e.bout)
            begin n_err++; $display("FAIL bp_next: got %h/%b in %0d want %h/%b in 4", diff, bout, cyc, e.diff, e.bout); end
        take_out();
    endtask

    task automatic test_reset_mid();
        int   cyc;
        exp_t e;
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (diff !== '0)        begin n_err++; $display("FAIL rstmid_diff: got %h want 0", diff); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1);
        wait_out(cyc);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++; if (out_valid !== 1'b1 || diff !== 32'h0000_000F || diff !== e.diff)
            begin n_err++; $display("FAIL rstmid_after: got ov=%b %h want ov=1 0000000f", out_valid, diff); end
        take_out();
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            wait_out(cyc);
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            n_cmp++; if (out_valid !== 1'b1 || diff !== e.diff || bout !== e.bout || zero !== e.zero)
                begin n_err++; $display("FAIL b2b%0d: got ov=%b %h/%b/%b want ov=1 %h/%b/%b", i, out_valid, diff, bout, zero, e.diff, e.bout, e.zero); end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_slice_subtractor.md
Name: seq_slice_subtractor

Overview:
- Multi-cycle unsigned subtractor computing diff = a - b - bin over WIDTH-bit operands.
- Processes one SLICE-bit slice per clock, LSB first, and ripples the borrow between slices in a register.
- Sits in the arithmetic datapath beside the registered adder; uses valid/ready handshakes on input and output.
- Trades latency for a narrow SLICE-bit subtract cell.

Parameters:
- WIDTH, 32: operand and result width; must be an integer multiple of SLICE.
- SLICE, 8: bits processed per cycle.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, bin presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0.

Behaviour:
- NSLICE = WIDTH/SLICE.
- Reset values (asynchronous, on rst assertion): state=IDLE, out_valid=0, diff=0, bout=0, zero=0, slice index=0, borrow register=0. in_ready decodes state==IDLE, so in_ready=1 while in reset.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, and bin (into the borrow register); index<=0; go to RUN. Inputs after capture are ignored.
  - RUN: each cycle compute {borrow_n, d} = {1'b0,a_s} - {1'b0,b_s} - borrow for slice[index].
    - Write d into diff[index*SLICE +: SLICE]; borrow<=borrow_n; index<=index+1.
    - On the slice with index==NSLICE-1, go to DONE, set bout=borrow_n, and set zero from the full assembled diff.
  - DONE: out_valid=1. diff, bout and zero are held stable while out_ready=0. On out_ready, out_valid<=0 and go to IDLE.
- Latency: acceptance at edge E0 gives out_valid=1 after edge E_NSLICE (4 cycles at defaults).
- Throughput: one result per NSLICE+2 cycles minimum. There is no overlap of input acceptance with DONE.
- diff is cleared to 0 on acceptance so partial results never alias previous data. Upper slices read 0 during RUN.
- in_ready=0 in RUN and DONE; in_valid asserted there is ignored and does not queue.
- bin=1 with a==b gives diff=all ones, bout=1.
- Borrow width rule: each slice subtract is SLICE+1 bits wide; bit SLICE is the borrow-out.
- Reset mid-operation aborts the transaction: outputs return to reset values immediately, and the result is discarded.
- out_ready is ignored outside DONE.

Decomposition:
- Package seq_slice_sub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function nslice(WIDTH, SLICE);
  - index width = $clog2(NSLICE).
- Sub-module sub_slice: combinational SLICE-bit subtract cell.
  - Inputs: a_s, b_s, borrow_in.
  - Outputs: d, borrow_out.
  - Instantiated once and muxed by index.
- Elaboration check that WIDTH % SLICE == 0.

Test Plan:
- a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, zero=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0x00000100, b=0x00000001, bin=0 -> diff=0x000000FF, bout=0; borrow ripples from slice 0 into slice 1.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, zero=0.
- a=0x12345678, b=0x12345677, bin=1 -> diff=0x00000000, zero=1, bout=0.
- Backpressure: result ready, out_ready held low 5 cycles while in_valid pulses with new operands -> diff, bout and zero stable, in_ready=0, new operands ignored; after out_ready, the next accept computes correctly.
- rst asserted during slice 2 of 0xFFFF0000-0x0000FFFF -> out_valid=0, diff=0 immediately, in_ready=1. After release, 0x10-0x01 gives diff=0x0000000F.
